// File: rtl/out_uart_pkg.sv
// Shared encodings for the tinycpu serial output port: CPU control states,
// the OUT opcode and the transmit FSM states.
// Optional feature macro: OUT_UART_PARITY_EN (adds an even-parity bit per byte).
package out_uart_pkg;

  // tinycpu control-state encodings (cs)
  localparam logic [2:0] FETCHA = 3'd0;
  localparam logic [2:0] FETCHB = 3'd1;
  localparam logic [2:0] EXECA  = 3'd2;
  localparam logic [2:0] EXECB  = 3'd3;

  // tinycpu opcodes (ir[15:12])
  localparam logic [3:0] PUSH = 4'h0;
  localparam logic [3:0] OUT  = 4'he;

  // Transmit FSM states
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef OUT_UART_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } tx_state_e;

  // Write strobe decode: an OUT instruction in its first execute state
  function automatic logic is_out_write(input logic [2:0] cs, input logic [15:0] ir);
    return (cs == EXECA) && (ir[15:12] == OUT);
  endfunction

endpackage

// File: rtl/out_fifo.sv
// Small synchronous FIFO for captured OUT words. A push while full is only
// accepted when a pop happens on the same edge.
module out_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [15:0]              din,
  output logic [15:0]              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr_q];
  assign level   = cnt_q;

  // Storage array; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= din;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/out_uart.sv
// Serial output port for the tinycpu: snoops OUT writes into a FIFO and sends
// each 16-bit word as two UART bytes, low byte first.
// Optional feature macro: OUT_UART_PARITY_EN (8E1 framing instead of 8N1).
module out_uart
  import out_uart_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             cs,
  input  logic [15:0]            ir,
  input  logic [15:0]            dbus,
  input  logic                   ovf_clr,
  output logic                   txd,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          hi_q, hi_d;
  logic [15:0]   sh_q, sh_d;
  logic          ovf_q;
  logic          wr, pop, full, empty, tick;
  logic [15:0]   fifo_dout;
`ifdef OUT_UART_PARITY_EN
  logic          par_q, par_d;
`endif

  assign wr   = is_out_write(cs, ir);
  assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

  out_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr),
    .pop   (pop),
    .din   (dbus),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Sticky overflow: a drop on the same edge as ovf_clr wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   ovf_q <= 1'b0;
    else if (wr && full && !pop)  ovf_q <= 1'b1;
    else if (ovf_clr)             ovf_q <= 1'b0;
  end

  assign overflow = ovf_q;
  assign busy     = (state_q != StIdle) || (level != '0);

  // Transmit next-state, shifter and line output
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    hi_d    = hi_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    txd     = 1'b1;
`ifdef OUT_UART_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = fifo_dout;
          hi_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        txd = 1'b0;
        if (tick) begin
          bit_d   = '0;
          state_d = StData;
`ifdef OUT_UART_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      StData: begin
        txd = sh_q[0];
        if (tick) begin
          // Shifting right leaves the high byte in sh_q[7:0] after the low byte
          sh_d  = {1'b0, sh_q[15:1]};
          bit_d = bit_q + 3'd1;
`ifdef OUT_UART_PARITY_EN
          par_d = par_q ^ sh_q[0];
          if (bit_q == 3'd7) state_d = StParity;
`else
          if (bit_q == 3'd7) state_d = StStop;
`endif
        end
      end
`ifdef OUT_UART_PARITY_EN
      StParity: begin
        txd = par_q;
        if (tick) state_d = StStop;
      end
`endif
      StStop: begin
        txd = 1'b1;
        if (tick) begin
          if (!hi_q) begin
            hi_d    = 1'b1;
            state_d = StStart;
          end else if (!empty) begin
            // Chain straight into the next word with no idle gap
            pop     = 1'b1;
            sh_d    = fifo_dout;
            hi_d    = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Baud counter restarts on every state change
    if (state_d != state_q) cnt_d = '0;
  end

  // Transmit state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      hi_q    <= hi_d;
      sh_q    <= sh_d;
    end
  end

`ifdef OUT_UART_PARITY_EN
  // Running parity of the byte being sent
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`endif

endmodule

// File: tb/tb_out_uart.sv
// Self-checking bench for out_uart with CLKS_PER_BIT=4, DEPTH=4.
// A line monitor decodes txd and compares each word against a scoreboard queue.
module tb_out_uart;
  import out_uart_pkg::*;

  localparam int unsigned CPB = 4;
`ifdef OUT_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  cs;
  logic [15:0] ir;
  logic [15:0] dbus;
  logic        ovf_clr;
  logic        txd, busy, overflow;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  out_uart #(
    .DEPTH        (4),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .ir       (ir),
    .dbus     (dbus),
    .ovf_clr  (ovf_clr),
    .txd      (txd),
    .busy     (busy),
    .level    (level),
    .overflow (overflow)
  );

  // Line monitor: samples mid-bit on the falling clock edge
  bit         rx_busy = 0;
  bit         rx_hi = 0;
  int         rx_t = 0;
  logic [7:0] rx_byte, rx_lo;
  logic [15:0] rx_word, rx_exp;
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      rx_busy = 0;
      rx_hi   = 0;
    end else if (!rx_busy) begin
      if (txd === 1'b0) begin
        rx_busy = 1;
        rx_t    = 0;
      end
    end else begin
      rx_t++;
      if (rx_t % CPB == 2) begin
        automatic int k = (rx_t - 2) / CPB;
        if (k == 0) begin
          checks++;
          if (txd !== 1'b0) begin
            errors++;
            $display("FAIL rx_start: got %b want 0", txd);
          end
        end else if (k <= 8) begin
          rx_byte[k-1] = txd;
        end else if (k == NB - 1) begin
          checks++;
          if (txd !== 1'b1) begin
            errors++;
            $display("FAIL rx_stop: got %b want 1", txd);
          end
          rx_busy = 0;
          if (!rx_hi) begin
            rx_lo = rx_byte;
            rx_hi = 1;
          end else begin
            rx_hi   = 0;
            rx_word = {rx_byte, rx_lo};
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rx_word: got %h want none", rx_word);
            end else begin
              rx_exp = exp_q.pop_front();
              if (rx_word !== rx_exp) begin
                errors++;
                $display("FAIL rx_word: got %h want %h", rx_word, rx_exp);
              end
            end
          end
        end else begin
          checks++;
          if (txd !== ^rx_byte) begin
            errors++;
            $display("FAIL rx_parity: got %b want %b", txd, ^rx_byte);
          end
        end
      end
    end
  end

  task automatic write_word(input logic [15:0] d);
    @(negedge clk);
    cs   = EXECA;
    ir   = {OUT, 12'h123};
    dbus = d;
    @(negedge clk);
    cs   = FETCHA;
    ir   = '0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending busy=%b want 0 pending", name, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    reset = 1'b0;
    #1;
    checks++;
    if ({txd, busy, level, overflow} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_vals: got txd=%b busy=%b level=%0d ovf=%b want 1 0 0 0",
               txd, busy, level, overflow);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_idle: got %0d low cycles want 0", bad);
    end
  endtask

  task automatic test_single_word(input logic [15:0] w);
    logic [NB*2-1:0] bits;
    int bad = 0;
`ifdef OUT_UART_PARITY_EN
    bits = {1'b1, ^w[15:8], w[15:8], 1'b0, 1'b1, ^w[7:0], w[7:0], 1'b0};
`else
    bits = {1'b1, w[15:8], 1'b0, 1'b1, w[7:0], 1'b0};
`endif
    exp_q.push_back(w);
    write_word(w);
    checks++;
    if (txd !== 1'b1 || level !== 3'd1) begin
      errors++;
      $display("FAIL single_accept: got txd=%b level=%0d want 1 1", txd, level);
    end
    for (int i = 0; i < NB * 2 * CPB; i++) begin
      @(negedge clk);
      if (txd !== bits[i / CPB]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_wave %h: got %0d wrong cycles want 0", w, bad);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || level !== 3'd0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got busy=%b level=%0d txd=%b want 0 0 1", busy, level, txd);
    end
  endtask

  task automatic test_decode();
    @(negedge clk);
    cs = EXECA;  ir = {PUSH, 12'h000}; dbus = 16'hdead;
    @(negedge clk);
    cs = FETCHA; ir = {OUT, 12'h000};  dbus = 16'hbeef;
    @(negedge clk);
    cs = EXECB;  ir = {OUT, 12'h000};
    @(negedge clk);
    cs = FETCHA; ir = '0;
    checks++;
    if (level !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL decode: got level=%0d busy=%b want 0 0", level, busy);
    end
  endtask

  task automatic burst(input logic [15:0] base, input bit clr_last);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cs      = EXECA;
      ir      = {OUT, 12'h000};
      dbus    = base + 16'(k);
      ovf_clr = clr_last && (k == 5);
      if (k < 5) exp_q.push_back(base + 16'(k));
    end
    @(negedge clk);
    cs      = FETCHA;
    ir      = '0;
    ovf_clr = 1'b0;
  endtask

  task automatic test_overflow();
    int n = 0;
    burst(16'd1, 1'b0);
    checks++;
    if (overflow !== 1'b1 || level !== 3'd4) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b level=%0d want 1 4", overflow, level);
    end
    // Five chained words: busy falls exactly 396 cycles from here
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 396) begin
      errors++;
      $display("FAIL ovf_b2b_len: got %0d cycles want 396", n);
    end
    wait_drain("ovf1");
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got %b want 0", overflow);
    end
    burst(16'h0070, 1'b1);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins: got %b want 1", overflow);
    end
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr2: got %b want 0", overflow);
    end
    wait_drain("ovf2");
  endtask

  task automatic test_reset_mid_frame();
    exp_q.push_back(16'hc3a5);
    write_word(16'hc3a5);
    write_word(16'h5555);
    repeat (48) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || level !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got txd=%b level=%0d busy=%b want 1 0 0", txd, level, busy);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_quiet: got txd=%b busy=%b want 1 0", txd, busy);
    end
    exp_q.push_back(16'h1234);
    write_word(16'h1234);
    wait_drain("after_reset");
  endtask

`ifdef OUT_UART_PARITY_EN
  task automatic test_parity();
    logic p_lo = 1'bx, p_hi = 1'bx;
    exp_q.push_back(16'h0103);
    write_word(16'h0103);
    for (int i = 0; i < 88; i++) begin
      @(negedge clk);
      if (i == 9 * CPB + 2)  p_lo = txd;
      if (i == 20 * CPB + 2) p_hi = txd;
    end
    checks++;
    if (p_lo !== 1'b0 || p_hi !== 1'b1) begin
      errors++;
      $display("FAIL parity_bits: got lo=%b hi=%b want 0 1", p_lo, p_hi);
    end
    wait_drain("parity");
  endtask
`endif

  initial begin
    cs      = FETCHA;
    ir      = '0;
    dbus    = '0;
    ovf_clr = 1'b0;
    test_reset();
    test_single_word(16'ha55a);
    test_decode();
    test_overflow();
    test_reset_mid_frame();
    test_single_word(16'h0f31);
`ifdef OUT_UART_PARITY_EN
    test_parity();
`endif
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
